flash_arbiter_multi: RTL and testbench

//  N-channel arbiter for the single QSPI flash_reader; generalises the 2-reader arbiter.

---
 rtl/flash_arbiter_multi.sv | 148 ++++++++++++++
 tb/tb_flash_arbiter_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter_multi.sv
// rtl/flash_arbiter_multi.sv - N-channel request arbiter in front of the single QSPI flash_reader
// Optional macro FLASH_ARBITER_RR_EN selects round-robin grant; default is fixed priority (lowest index wins).
module flash_arbiter_multi #(
    parameter int                CHANNELS  = 2,
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] USER_BASE = ADDR_W'(24'h200000),
    localparam int               CH_W      = $clog2(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        req_valid,
    input  logic [CHANNELS*ADDR_W-1:0] req_address,
    input  logic [CHANNELS-1:0]        req_size,
    output logic [CHANNELS-1:0]        req_ready,
    output logic [DATA_W-1:0]          read_data,
    output logic                       busy,
    output logic [CH_W-1:0]            grant_id,
    output logic                       reader_valid,
    output logic [ADDR_W-1:0]          reader_address,
    output logic                       reader_size,
    input  logic [DATA_W-1:0]          reader_data,
    input  logic                       reader_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CH_W-1:0]     r_grant_id;
    logic [ADDR_W-1:0]   r_reader_address;
    logic                r_reader_size;
    logic [DATA_W-1:0]   r_read_data;
    logic                w_any;
    logic [CH_W-1:0]     w_win;
    logic [ADDR_W-1:0]   w_addr_sum;
    logic                w_grant_now;

`ifdef FLASH_ARBITER_RR_EN
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W:0]       w_idx;
    logic [CH_W:0]       w_ptr_inc;
    logic [CH_W-1:0]     w_ptr_next;

    // Scan downward so the channel closest after the pointer is the last (winning) assignment.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
            if (int'(w_idx) >= CHANNELS) begin
                w_idx = w_idx - (CH_W + 1)'(CHANNELS);
            end
            if (req_valid[w_idx[CH_W-1:0]]) begin
                w_win = w_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_inc  = {1'b0, w_win} + (CH_W + 1)'(1);
        w_ptr_next = w_ptr_inc[CH_W-1:0];
        if (int'(w_ptr_inc) >= CHANNELS) begin
            w_ptr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_now) begin
            r_rr_ptr <= w_ptr_next;
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_win = CH_W'(i);
            end
        end
    end
`endif

    assign w_any       = |req_valid;
    assign w_grant_now = (r_state == S_IDLE) && w_any;
    // Sum is truncated to ADDR_W, so addresses past the top wrap silently.
    assign w_addr_sum  = req_address[w_win*ADDR_W +: ADDR_W] + USER_BASE;

    always_comb begin
        w_next_state = r_state;
        reader_valid = 1'b0;
        busy         = 1'b1;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                reader_valid = 1'b1;
                if (reader_ready) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                req_ready[r_grant_id] = 1'b1;
                w_next_state          = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_grant_id       <= '0;
            r_reader_address <= '0;
            r_reader_size    <= 1'b0;
            r_read_data      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_now) begin
                r_grant_id       <= w_win;
                r_reader_address <= w_addr_sum;
                r_reader_size    <= req_size[w_win];
            end
            if ((r_state == S_ISSUE) && reader_ready) begin
                r_read_data <= reader_data;
            end
        end
    end

    assign grant_id       = r_grant_id;
    assign reader_address = r_reader_address;
    assign reader_size    = r_reader_size;
    assign read_data      = r_read_data;

endmodule

// File: tb/tb_flash_arbiter_multi.sv
// tb/tb_flash_arbiter_multi.sv - directed self-checking bench for flash_arbiter_multi (CHANNELS=4)
module tb_flash_arbiter_multi;

    localparam int CHANNELS = 4;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int CH_W     = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [CHANNELS-1:0]        req_valid;
    logic [CHANNELS*ADDR_W-1:0] req_address;
    logic [CHANNELS-1:0]        req_size;
    logic [CHANNELS-1:0]        req_ready;
    logic [DATA_W-1:0]          read_data;
    logic                       busy;
    logic [CH_W-1:0]            grant_id;
    logic                       reader_valid;
    logic [ADDR_W-1:0]          reader_address;
    logic                       reader_size;
    logic [DATA_W-1:0]          reader_data;
    logic                       reader_ready;

    int checks   = 0;
    int failures = 0;

    flash_arbiter_multi #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .USER_BASE(24'h200000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_address   (req_address),
        .req_size      (req_size),
        .req_ready     (req_ready),
        .read_data     (read_data),
        .busy          (busy),
        .grant_id      (grant_id),
        .reader_valid  (reader_valid),
        .reader_address(reader_address),
        .reader_size   (reader_size),
        .reader_data   (reader_data),
        .reader_ready  (reader_ready)
    );

    always #5 clk = ~clk;

    // A granted requester must keep its request up for the whole ISSUE phase.
    always @(negedge clk) begin
        if (!reset && reader_valid && !req_valid[grant_id]) begin
            failures++;
            $error("FAIL protocol_req_dropped grant=%0d req_valid=%b", grant_id, req_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int ch, input logic [ADDR_W-1:0] a);
        req_address[ch*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic serve(input logic [DATA_W-1:0] d);
        reader_ready = 1'b1;
        reader_data  = d;
        tick();
        reader_ready = 1'b0;
        reader_data  = '0;
    endtask

    logic [CH_W-1:0] exp_order [5];

    initial begin
`ifdef FLASH_ARBITER_RR_EN
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        reset        = 1'b1;
        req_valid    = '0;
        req_address  = '0;
        req_size     = '0;
        reader_data  = '0;
        reader_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_reader_valid", 64'(reader_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_grant_id", 64'(grant_id), 64'h0);
        chk("rst_reader_address", 64'(reader_address), 64'h0);
        chk("rst_reader_size", 64'(reader_size), 64'h0);
        chk("rst_read_data", 64'(read_data), 64'h0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'h0);

        // Single channel 0 transfer, reader answers five cycles after reader_valid.
        set_addr(0, 24'h000010);
        req_size  = 4'b0001;
        req_valid = 4'b0001;
        tick();
        chk("t1_reader_valid", 64'(reader_valid), 64'h1);
        chk("t1_reader_address", 64'(reader_address), 64'h200010);
        chk("t1_reader_size", 64'(reader_size), 64'h1);
        chk("t1_grant", 64'(grant_id), 64'h0);
        chk("t1_busy", 64'(busy), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_wait_valid", 64'(reader_valid), 64'h1);
            chk("t1_wait_ready", 64'(req_ready), 64'h0);
        end
        serve(32'hDEADBEEF);
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        chk("t1_read_data", 64'(read_data), 64'hDEADBEEF);
        chk("t1_done_valid", 64'(reader_valid), 64'h0);
        req_valid = 4'b0000;
        tick();
        chk("t1_ready_gone", 64'(req_ready), 64'h0);
        chk("t1_idle", 64'(busy), 64'h0);
        chk("t1_data_held", 64'(read_data), 64'hDEADBEEF);

        // Channels 1 and 3 together: ch1 first, ch3 stays pending.
        set_addr(1, 24'h000100);
        set_addr(3, 24'h000300);
        req_size  = 4'b1000;
        req_valid = 4'b1010;
        tick();
        chk("t2_grant_a", 64'(grant_id), 64'h1);
        chk("t2_addr_a", 64'(reader_address), 64'h200100);
        chk("t2_size_a", 64'(reader_size), 64'h0);
        tick();
        serve(32'h11111111);
        chk("t2_ready_a", 64'(req_ready), 64'h2);
        chk("t2_data_a", 64'(read_data), 64'h11111111);
        req_valid = 4'b1000;
        tick();
        chk("t2_gap_ready", 64'(req_ready), 64'h0);
        chk("t2_gap_data", 64'(read_data), 64'h11111111);
        chk("t2_gap_busy", 64'(busy), 64'h0);
        tick();
        chk("t2_grant_b", 64'(grant_id), 64'h3);
        chk("t2_addr_b", 64'(reader_address), 64'h200300);
        chk("t2_size_b", 64'(reader_size), 64'h1);
        chk("t2_data_not_early", 64'(read_data), 64'h11111111);
        serve(32'h33333333);
        chk("t2_ready_b", 64'(req_ready), 64'h8);
        chk("t2_data_b", 64'(read_data), 64'h33333333);
        req_valid = 4'b0000;
        tick();

        // All four held high: grant sequence depends on the arbitration mode.
        for (int c = 0; c < CHANNELS; c++) begin
            set_addr(c, ADDR_W'(24'h000040 + c * 16));
        end
        req_size  = 4'b0000;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t3_grant", 64'(grant_id), 64'(exp_order[n]));
            chk("t3_addr", 64'(reader_address), 64'(24'h200040 + int'(exp_order[n]) * 16));
            serve(32'hA0000000 + 32'(n));
            chk("t3_ready_onehot", 64'(req_ready), 64'(4'b0001 << exp_order[n]));
            chk("t3_data", 64'(read_data), 64'(32'hA0000000 + 32'(n)));
            if (n == 4) begin
                req_valid = 4'b0000;
            end
            tick();
            chk("t3_idle_ready", 64'(req_ready), 64'h0);
        end

        // Address wrap past the top of the 24-bit space.
        set_addr(2, 24'hFFFFF0);
        req_valid = 4'b0100;
        tick();
        chk("t4_grant", 64'(grant_id), 64'h2);
        chk("t4_wrap_addr", 64'(reader_address), 64'h1FFFF0);
        serve(32'hCAFEF00D);
        chk("t4_ready", 64'(req_ready), 64'h4);
        req_valid = 4'b0000;
        tick();

        // Reset during ISSUE abandons the transfer; the held request is then served afresh.
        set_addr(0, 24'h000020);
        req_valid = 4'b0001;
        tick();
        chk("t5_issue", 64'(reader_valid), 64'h1);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid", 64'(reader_valid), 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_ready", 64'(req_ready), 64'h0);
        chk("t5_rst_data", 64'(read_data), 64'h0);
        reset = 1'b0;
        tick();
        chk("t5_regrant", 64'(grant_id), 64'h0);
        chk("t5_readdr", 64'(reader_address), 64'h200020);
        chk("t5_revalid", 64'(reader_valid), 64'h1);
        serve(32'h55AA55AA);
        chk("t5_ready", 64'(req_ready), 64'h1);
        chk("t5_data", 64'(read_data), 64'h55AA55AA);
        req_valid = 4'b0000;
        tick();

        // Stray reader_ready while idle must have no effect.
        reader_ready = 1'b1;
        reader_data  = 32'h12345678;
        tick();
        chk("t6_no_ready", 64'(req_ready), 64'h0);
        chk("t6_data_kept", 64'(read_data), 64'h55AA55AA);
        chk("t6_busy", 64'(busy), 64'h0);
        reader_ready = 1'b0;
        tick();
        chk("t6_no_ready_late", 64'(req_ready), 64'h0);
        chk("t6_data_kept_late", 64'(read_data), 64'h55AA55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
